// File: rtl/pkt_buf_pkg.sv
// Shared constants, descriptor type and FSM states for the packet-buffer read engine.
package pkt_buf_pkg;
  localparam int NUM_SLOTS       = 2;
  localparam int MEM_DEPTH       = 1518;
  localparam int SLOT_WIDTH      = $clog2(NUM_SLOTS);
  localparam int BYTE_ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int ADDR_WIDTH      = SLOT_WIDTH + BYTE_ADDR_WIDTH;
  localparam int FIFO_DEPTH      = 4;

  typedef struct packed {
    logic [SLOT_WIDTH-1:0]      slot;
    logic [BYTE_ADDR_WIDTH-1:0] len;
  } pkt_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } rd_state_t;

  function automatic logic [BYTE_ADDR_WIDTH-1:0] clamp_len(input logic [BYTE_ADDR_WIDTH-1:0] len);
    return (len > BYTE_ADDR_WIDTH'(MEM_DEPTH)) ? BYTE_ADDR_WIDTH'(MEM_DEPTH) : len;
  endfunction
endpackage

// File: rtl/pkt_rd_fifo.sv
// Small output FIFO holding {last, data} beats between the BRAM read port and the stream.
module pkt_rd_fifo
  import pkt_buf_pkg::*;
#(
  parameter int W = 9
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          i_push,
  input  logic [W-1:0]                  i_data,
  input  logic                          i_pop,
  output logic [W-1:0]                  o_head,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_occ
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;

  assign o_head  = r_mem[r_rp];
  assign o_empty = (r_cnt == '0);
  assign o_occ   = r_cnt;

  // Storage is reset too so the stream outputs read zero straight out of reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (i_pop) r_rp <= r_rp + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/pkt_buf_reader.sv
// Streams one buffered frame per descriptor out of the packet BRAM, then frees its slot.
// Optional frame/byte counters are built when PKT_BUF_RD_STATS_EN is defined.
module pkt_buf_reader
  import pkt_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       desc_valid,
  output logic                       desc_ready,
  input  logic [SLOT_WIDTH-1:0]      desc_slot,
  input  logic [BYTE_ADDR_WIDTH-1:0] desc_len,
  output logic                       rd_en,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  output logic                       slot_free_valid,
  output logic [SLOT_WIDTH-1:0]      slot_free_id,
  output logic                       busy
`ifdef PKT_BUF_RD_STATS_EN
  ,
  output logic [31:0]                stat_frames,
  output logic [31:0]                stat_bytes
`endif
);
  localparam int FW = DATA_WIDTH + 1;
  localparam logic [BYTE_ADDR_WIDTH-1:0] LEN_ONE = 1;

  rd_state_t                  r_state, w_next;
  pkt_desc_t                  r_desc, w_desc_in;
  logic [BYTE_ADDR_WIDTH-1:0] r_issue_cnt;
  logic                       r_pend, r_pend_last, r_alive;
  logic                       w_hs, w_issue, w_pop, w_empty, w_head_last;
  logic [2:0]                 w_occ;
  logic [3:0]                 w_outstanding;
  logic [FW-1:0]              w_head;
  logic [DATA_WIDTH-1:0]      w_head_data;

  assign w_desc_in.slot = desc_slot;
  assign w_desc_in.len  = clamp_len(desc_len);

  // r_alive keeps desc_ready low while reset is held.
  assign desc_ready    = r_alive && (r_state == ST_IDLE);
  assign w_hs          = desc_valid && desc_ready;
  // r_pend is the one read whose data is on rd_data but not yet in the FIFO.
  assign w_outstanding = {1'b0, w_occ} + {3'b0, r_pend};
  assign w_issue       = (r_state == ST_STREAM) && (r_issue_cnt < r_desc.len) &&
                         (w_outstanding < 4'(FIFO_DEPTH));
  assign w_pop         = m_valid && m_ready;

  pkt_rd_fifo #(.W(FW)) u_fifo (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_push (r_pend),
    .i_data ({r_pend_last, rd_data}),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_empty(w_empty),
    .o_occ  (w_occ)
  );

  assign {w_head_last, w_head_data} = w_head;
  assign m_valid         = !w_empty;
  assign m_data          = w_head_data;
  assign m_last          = w_head_last;
  assign rd_en           = w_issue;
  assign rd_addr         = w_issue ? {r_desc.slot, r_issue_cnt} : '0;
  assign busy            = (r_state != ST_IDLE);
  assign slot_free_valid = (r_state == ST_DONE);
  assign slot_free_id    = (r_state == ST_DONE) ? r_desc.slot : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_hs) w_next = (w_desc_in.len == '0) ? ST_DONE : ST_STREAM;
      ST_STREAM: if (w_pop && w_head_last) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_desc      <= '0;
      r_issue_cnt <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_alive     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_alive     <= 1'b1;
      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_issue_cnt == r_desc.len - LEN_ONE);
      if (w_hs) begin
        r_desc      <= w_desc_in;
        r_issue_cnt <= '0;
      end else if (w_issue) begin
        r_issue_cnt <= r_issue_cnt + LEN_ONE;
      end
    end
  end

`ifdef PKT_BUF_RD_STATS_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stat_frames <= '0;
      stat_bytes  <= '0;
    end else begin
      if (slot_free_valid) stat_frames <= stat_frames + 32'd1;
      if (w_pop)           stat_bytes  <= stat_bytes + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pkt_buf_reader.sv
// Scoreboard bench for pkt_buf_reader: a BRAM model feeds reads, a negedge monitor checks beats.
module tb_pkt_buf_reader;
  import pkt_buf_pkg::*;

  logic                       CLK = 1'b0;
  logic                       RST_N = 1'b0;
  logic                       desc_valid = 1'b0;
  logic                       desc_ready;
  logic [SLOT_WIDTH-1:0]      desc_slot = '0;
  logic [BYTE_ADDR_WIDTH-1:0] desc_len = '0;
  logic                       rd_en;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic [7:0]                 rd_data = '0;
  logic                       m_valid;
  logic                       m_ready = 1'b1;
  logic [7:0]                 m_data;
  logic                       m_last;
  logic                       slot_free_valid;
  logic [SLOT_WIDTH-1:0]      slot_free_id;
  logic                       busy;
`ifdef PKT_BUF_RD_STATS_EN
  logic [31:0]                stat_frames, stat_bytes;
`endif

  pkt_buf_reader #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_slot(desc_slot), .desc_len(desc_len),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .slot_free_valid(slot_free_valid), .slot_free_id(slot_free_id), .busy(busy)
`ifdef PKT_BUF_RD_STATS_EN
    , .stat_frames(stat_frames), .stat_bytes(stat_bytes)
`endif
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [0:(1<<ADDR_WIDTH)-1];
  always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr];

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [8:0] q[$];
  int  cur_slot = 0, cur_len = 0, frame_seq = 0, zero_req = 0;
  bit  rand_en = 1'b0;

  // Monitor-owned state
  int  seen_seq = 0, zero_ack = 0, frees = 0, cyc = 0;
  int  exp_issue = 0, fr_iss = 0, fr_acc = 0, fr_first = 0, fr_last = 0;
  bit  fr_has = 0, exp_free = 0, chk_rdy = 0, prev_stall = 0;
  logic [8:0] prev_beat = '0, w_exp;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1 m_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      prev_stall = 0; exp_free = 0; chk_rdy = 0;
    end else begin
      if (frame_seq != seen_seq) begin
        seen_seq = frame_seq; exp_issue = 0; fr_iss = 0; fr_acc = 0; fr_has = 0;
      end
      if (chk_rdy) begin
        chk("ready_after_free", desc_ready, 1);
        chk_rdy = 0;
      end
      if (exp_free || zero_req != zero_ack) begin
        chk("free_valid", slot_free_valid, 1);
        chk("free_id", slot_free_id, cur_slot);
        if (!exp_free) zero_ack++;
        exp_free = 0; frees++; chk_rdy = 1;
      end else if (slot_free_valid) begin
        chk("spurious_free", slot_free_valid, 0);
      end
      if (rd_en) begin
        chk("rd_addr", rd_addr, {cur_slot[SLOT_WIDTH-1:0], exp_issue[BYTE_ADDR_WIDTH-1:0]});
        chk("rd_in_range", exp_issue < cur_len, 1);
        exp_issue++; fr_iss++;
      end
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_beat", {m_last, m_data}, prev_beat);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("unexpected_beat", m_valid, 0);
        else begin
          w_exp = q.pop_front();
          chk("beat_data", m_data, w_exp[7:0]);
          chk("beat_last", m_last, w_exp[8]);
        end
        if (!fr_has) fr_first = cyc;
        fr_has = 1; fr_last = cyc; fr_acc++;
        if (m_last) exp_free = 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_beat  = {m_last, m_data};
      if (busy) chk("outstanding_le4", (fr_iss - fr_acc) <= 4, 1);
    end
  end

  task automatic send_frame(input int slot, input int len, input bit wait_done);
    int elen, n, fr0;
    elen = (len > MEM_DEPTH) ? MEM_DEPTH : len;
    n = 0;
    do begin @(negedge CLK); n++; end while (!desc_ready && n < 200);
    chk("desc_ready_wait", desc_ready, 1);
    cur_slot = slot; cur_len = elen; frame_seq++;
    for (int i = 0; i < elen; i++) q.push_back({i == elen - 1, mem[slot * 2048 + i]});
    desc_valid = 1'b1;
    desc_slot  = SLOT_WIDTH'(slot);
    desc_len   = BYTE_ADDR_WIDTH'(len);
    @(posedge CLK);
    #1 desc_valid = 1'b0;
    fr0 = frees;
    if (elen == 0) begin
      zero_req++;
      chk("len0_no_rd", rd_en, 0);
    end else begin
      chk("rd_en_cycle1", rd_en, 1);
      chk("m_valid_low_c1", m_valid, 0);
      @(posedge CLK);
      @(posedge CLK);
      #1 chk("m_valid_cycle3", m_valid, 1);
    end
    if (wait_done) begin
      n = 0;
      while (frees == fr0 && n < 6000) begin @(negedge CLK); n++; end
      chk("frame_freed", frees - fr0, 1);
      chk("beat_count", fr_acc, elen);
      chk("issue_count", fr_iss, elen);
      if (!rand_en && elen > 0) chk("no_bubbles", fr_last - fr_first + 1, elen);
      chk("queue_empty", q.size(), 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_desc_ready"}, desc_ready, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_free_valid"}, slot_free_valid, 0);
    chk({tag, "_free_id"}, slot_free_id, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    #1 chk_zero("rst");
    q.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("ready_after_rst", desc_ready, 1);
  endtask

  initial begin
    int n;
    for (int a = 0; a < (1 << ADDR_WIDTH); a++) begin
      logic [11:0] av;
      av = 12'(a);
      mem[a] = av[7:0] ^ av[11:4] ^ 8'hA5;
    end
    #12 chk_zero("por");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("ready_after_por", desc_ready, 1);
    chk("busy_after_por", busy, 0);

    send_frame(0, 64, 1);
    send_frame(1, 1518, 1);
    rand_en = 1'b1;
    send_frame(0, 200, 1);
    rand_en = 1'b0;
    repeat (2) @(posedge CLK);
    send_frame(1, 1, 1);
    send_frame(0, 0, 1);
    send_frame(1, 2000, 1);

    // Abort a frame mid-stream with reset, then recover.
    send_frame(0, 64, 0);
    n = 0;
    while (fr_acc < 10 && n < 500) begin @(negedge CLK); n++; end
    chk("reached_beat10", fr_acc >= 10, 1);
    #2 pulse_reset();
    send_frame(1, 8, 1);

    @(negedge CLK);
    #2 pulse_reset();
    send_frame(0, 64, 1);
    send_frame(1, 1, 1);
    send_frame(0, 100, 1);
    @(negedge CLK);
`ifdef PKT_BUF_RD_STATS_EN
    chk("stat_frames", stat_frames, 3);
    chk("stat_bytes", stat_bytes, 165);
`endif
    repeat (3) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
